// File: rtl/four_buttons.sv
// Four active-low push buttons: 2-FF synchronisers, per-button debounce,
// press/release strobes and a first-word-fall-through event queue.
module four_buttons #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_n,
  output logic [3:0] btn_state,
  output logic [3:0] btn_press,
  output logic [3:0] btn_release,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [2:0] evt_code,
  output logic       evt_overflow
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int IDX_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(FIFO_DEPTH);

  logic [3:0]                  sync1_q, sync1_d;
  logic [3:0]                  sync2_q, sync2_d;
  logic [3:0][CNT_W-1:0]       cnt_q, cnt_d;
  logic [3:0]                  state_q, state_d;
  logic [3:0]                  press_q, press_d;
  logic [3:0]                  release_q, release_d;
  logic [3:0]                  pending_q, pending_d;
  logic [3:0]                  ptype_q, ptype_d;
  logic [FIFO_DEPTH-1:0][2:0]  mem_q, mem_d;
  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
  logic                        overflow_q, overflow_d;

  logic       sel_valid_s;
  logic [1:0] sel_idx_s;
  logic [3:0] clr_mask_s;
  logic       fifo_empty_s;
  logic       fifo_full_s;
  logic       pop_s;
  logic       push_s;
  logic       drop_s;

  // Synchroniser and debounce counters; a flip is accepted on the
  // DEBOUNCE_CYCLES-th consecutive differing sample.
  always_comb begin
    sync1_d   = ~btn_n;
    sync2_d   = sync1_q;
    cnt_d     = cnt_q;
    state_d   = state_q;
    press_d   = 4'b0000;
    release_d = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] == state_q[i]) begin
        cnt_d[i] = {CNT_W{1'b0}};
      end else if (cnt_q[i] == CNT_LAST) begin
        cnt_d[i]     = {CNT_W{1'b0}};
        state_d[i]   = sync2_q[i];
        press_d[i]   = sync2_q[i];
        release_d[i] = ~sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Fixed-priority arbiter: lowest pending index wins.
  always_comb begin
    casez (pending_q)
      4'b???1: begin sel_valid_s = 1'b1; sel_idx_s = 2'd0; end
      4'b??10: begin sel_valid_s = 1'b1; sel_idx_s = 2'd1; end
      4'b?100: begin sel_valid_s = 1'b1; sel_idx_s = 2'd2; end
      4'b1000: begin sel_valid_s = 1'b1; sel_idx_s = 2'd3; end
      default: begin sel_valid_s = 1'b0; sel_idx_s = 2'd0; end
    endcase
  end

  // Queue control; a pop in the same cycle frees a slot for a push when full.
  always_comb begin
    fifo_empty_s = (wr_ptr_q == rd_ptr_q);
    fifo_full_s  = ((wr_ptr_q - rd_ptr_q) == PTR_FULL);
    pop_s        = ~fifo_empty_s & evt_ready;
    push_s       = sel_valid_s & (~fifo_full_s | pop_s);
    drop_s       = sel_valid_s & fifo_full_s & ~pop_s;
    if (sel_valid_s) begin
      clr_mask_s = 4'b0001 << sel_idx_s;
    end else begin
      clr_mask_s = 4'b0000;
    end
    pending_d  = (pending_q & ~clr_mask_s) | press_d | release_d;
    ptype_d    = (ptype_q & ~(press_d | release_d)) | press_d;
    overflow_d = overflow_q | drop_s;
    mem_d      = mem_q;
    if (push_s) begin
      mem_d[wr_ptr_q[IDX_W-1:0]] = {ptype_q[sel_idx_s], sel_idx_s};
    end else begin
      mem_d = mem_q;
    end
    wr_ptr_d = wr_ptr_q + PTR_W'(push_s);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_s);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 4'b0000;
      sync2_q    <= 4'b0000;
      cnt_q      <= '0;
      state_q    <= 4'b0000;
      press_q    <= 4'b0000;
      release_q  <= 4'b0000;
      pending_q  <= 4'b0000;
      ptype_q    <= 4'b0000;
      mem_q      <= '0;
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      overflow_q <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      press_q    <= press_d;
      release_q  <= release_d;
      pending_q  <= pending_d;
      ptype_q    <= ptype_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Outputs come straight from registers; evt_code is the queue head.
  always_comb begin
    btn_state    = state_q;
    btn_press    = press_q;
    btn_release  = release_q;
    evt_valid    = (wr_ptr_q != rd_ptr_q);
    evt_code     = mem_q[rd_ptr_q[IDX_W-1:0]];
    evt_overflow = overflow_q;
  end

endmodule

// File: tb/tb_four_buttons.sv
// Directed and randomised bench for four_buttons; a window/queue reference
// model predicts every output every cycle.
module tb_four_buttons;

  localparam int D     = 4;
  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic [3:0] btn_n;
  logic [3:0] btn_state;
  logic [3:0] btn_press;
  logic [3:0] btn_release;
  logic       evt_valid;
  logic       evt_ready;
  logic [2:0] evt_code;
  logic       evt_overflow;

  int n_tests = 0;
  int n_fail  = 0;

  four_buttons #(.DEBOUNCE_CYCLES(D), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_n        (btn_n),
    .btn_state    (btn_state),
    .btn_press    (btn_press),
    .btn_release  (btn_release),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_code     (evt_code),
    .evt_overflow (evt_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: two-sample pin delay, a window of the last D samples per
  // button (a flip needs the whole window to disagree with the level), pending
  // flags, and a bounded queue of event codes.
  logic [3:0]   m_s1, m_s2, m_state, m_press, m_rel, m_pend, m_ptype;
  logic [D-1:0] m_win [4];
  logic         m_ovf;
  logic [2:0]   m_q [$];

  task automatic model_reset();
    m_s1 = 4'h0; m_s2 = 4'h0; m_state = 4'h0; m_press = 4'h0; m_rel = 4'h0;
    m_pend = 4'h0; m_ptype = 4'h0; m_ovf = 1'b0;
    for (int i = 0; i < 4; i++) m_win[i] = '0;
    m_q.delete();
  endtask

  task automatic model_step();
    int  sel;
    int  size_before;
    bit  pop;
    logic smp;
    if (rst) begin
      model_reset();
    end else begin
      size_before = m_q.size();
      pop = (size_before > 0) && evt_ready;
      sel = -1;
      for (int i = 3; i >= 0; i--) if (m_pend[i]) sel = i;
      if (pop) void'(m_q.pop_front());
      if (sel >= 0) begin
        if (size_before < DEPTH || pop) m_q.push_back({m_ptype[sel], 2'(sel)});
        else m_ovf = 1'b1;
        m_pend[sel] = 1'b0;
      end
      m_press = 4'h0;
      m_rel   = 4'h0;
      for (int i = 0; i < 4; i++) begin
        smp = m_s2[i];
        m_win[i] = {m_win[i][D-2:0], smp};
        if ((m_state[i] && m_win[i] == '0) || (!m_state[i] && &m_win[i])) begin
          m_state[i] = smp;
          m_press[i] = smp;
          m_rel[i]   = ~smp;
          m_pend[i]  = 1'b1;
          m_ptype[i] = smp;
        end
      end
      m_s2 = m_s1;
      m_s1 = ~btn_n;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_model();
    chk("state",    8'(btn_state),    8'(m_state));
    chk("press",    8'(btn_press),    8'(m_press));
    chk("release",  8'(btn_release),  8'(m_rel));
    chk("valid",    8'(evt_valid),    8'(m_q.size() > 0));
    chk("overflow", 8'(evt_overflow), 8'(m_ovf));
    if (m_q.size() > 0) chk("code", 8'(evt_code), 8'(m_q[0]));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  initial begin
    rst = 1'b1; btn_n = 4'hF; evt_ready = 1'b0;
    model_reset();

    // Reset
    repeat (3) tick();
    chk("rst_state", 8'(btn_state), 8'h00);
    chk("rst_valid", 8'(evt_valid), 8'h00);
    chk("rst_code",  8'(evt_code),  8'h00);
    chk("rst_ovf",   8'(evt_overflow), 8'h00);
    rst = 1'b0;
    repeat (100) tick();
    chk("idle_valid", 8'(evt_valid), 8'h00);

    // Clean press of button 2
    btn_n = 4'b1011;
    repeat (5) tick();
    chk("press_early", 8'(btn_state), 8'h00);
    tick();
    chk("press_state", 8'(btn_state), 8'h04);
    chk("press_strobe", 8'(btn_press), 8'h04);
    tick();
    chk("press_strobe_off", 8'(btn_press), 8'h00);
    chk("press_valid", 8'(evt_valid), 8'h01);
    chk("press_code", 8'(evt_code), 8'h06);
    evt_ready = 1'b1;
    tick();
    chk("press_popped", 8'(evt_valid), 8'h00);
    btn_n = 4'hF;
    repeat (10) tick();
    chk("rel_state", 8'(btn_state), 8'h00);

    // Bounce on button 0
    btn_n = 4'hE; repeat (3) tick();
    btn_n = 4'hF; tick();
    btn_n = 4'hE; repeat (3) tick();
    btn_n = 4'hF; repeat (10) tick();
    chk("bounce_state", 8'(btn_state), 8'h00);
    chk("bounce_valid", 8'(evt_valid), 8'h00);

    // Simultaneous press, consumer always ready
    btn_n = 4'h0;
    repeat (6) tick();
    chk("simul_press", 8'(btn_press), 8'h0F);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("simul_valid", 8'(evt_valid), 8'h01);
      chk("simul_code", 8'(evt_code), 8'(4 + k));
    end
    tick();
    chk("simul_drained", 8'(evt_valid), 8'h00);
    btn_n = 4'hF;
    repeat (14) tick();

    // Overflow and pointer wrap over three rounds
    for (int r = 0; r < 3; r++) begin
      evt_ready = 1'b0;
      btn_n = 4'h0;
      repeat (10) tick();
      btn_n = 4'b0001;
      repeat (10) tick();
      chk("ovf_set", 8'(evt_overflow), 8'h01);
      evt_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
        chk("ovf_code", 8'(evt_code), 8'(4 + k));
        tick();
      end
      chk("ovf_drained", 8'(evt_valid), 8'h00);
      btn_n = 4'hF;
      repeat (14) tick();
      chk("ovf_sticky", 8'(evt_overflow), 8'h01);
    end

    // Reset two cycles before acceptance, button 1 held through reset
    rst = 1'b1; tick();
    rst = 1'b0; tick();
    chk("ovf_cleared", 8'(evt_overflow), 8'h00);
    evt_ready = 1'b0;
    btn_n = 4'b1101;
    repeat (D) tick();
    rst = 1'b1;
    repeat (2) tick();
    chk("mid_rst_state", 8'(btn_state), 8'h00);
    rst = 1'b0;
    repeat (D + 2) tick();
    chk("held_not_yet", 8'(evt_valid), 8'h00);
    tick();
    chk("held_valid", 8'(evt_valid), 8'h01);
    chk("held_code", 8'(evt_code), 8'h05);

    // Reset with two events queued
    btn_n = 4'b1100;
    repeat (8) tick();
    chk("q2_valid", 8'(evt_valid), 8'h01);
    rst = 1'b1;
    repeat (2) tick();
    chk("q2_rst_valid", 8'(evt_valid), 8'h00);
    chk("q2_rst_state", 8'(btn_state), 8'h00);
    rst = 1'b0;
    btn_n = 4'hF;
    repeat (10) tick();

    // Randomised activity
    for (int it = 0; it < 600; it++) begin
      if ($urandom_range(0, 3) == 0) btn_n = 4'($urandom());
      else btn_n = btn_n ^ (4'b0001 << $urandom_range(0, 3));
      for (int h = 0; h < int'($urandom_range(1, 10)); h++) begin
        evt_ready = ($urandom_range(0, 3) != 0);
        rst = ($urandom_range(0, 299) == 0);
        tick();
      end
      rst = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
